// File: rtl/yutorina_if_stage.sv
// yutorina_if_stage: instruction fetch stage in front of a scratch-pad memory (SPM).
// Issues one word fetch per cycle and delivers it to decode one cycle later.
// Handles downstream stalls, branch and exception redirects, and a HALT state.
// Optional feature: define YUTORINA_IF_RANGE_CHECK_EN to reject fetches outside
// the SPM window. A rejected fetch raises a one-cycle if_fault pulse.
// Without the macro, the upper pc bits alias onto the SPM and if_fault is tied low.
module yutorina_if_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] SPM_BASE     = 32'h0000_0000,
    parameter int          SPM_AW       = 12
) (
    input  logic              clk,
    input  logic              reset_,
    output logic [SPM_AW-1:0] i_addr,
    output logic              i_as_,
    input  logic [31:0]       i_r_data,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [31:0]       br_addr,
    input  logic              flush,
    input  logic [31:0]       flush_pc,
    input  logic              halt_req,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_insn,
    output logic              if_en,
    output logic              if_fault
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

`ifdef YUTORINA_IF_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    state_t      state;
    logic [31:0] pc;
    logic [31:0] if_pc_q;
    logic        valid_q;
    logic [31:0] hold_q;
    logic        hold_v;
    logic        window_hit;
    logic        in_window;

`ifdef YUTORINA_IF_RANGE_CHECK_EN
    logic        fault_q;
    logic        fault_lock;
`endif

    // Window decode.
    // When range checking is compiled out, every address counts as inside the window.
    always_comb begin
        window_hit = (pc[31:SPM_AW+2] == SPM_BASE[31:SPM_AW+2]);
        in_window  = !RANGE_CHECK || window_hit;
    end

    // SPM request side.
    // The strobe is only asserted when the fetch will really be consumed.
    always_comb begin
        i_addr = pc[SPM_AW+1:2];
        i_as_  = !((state == RUN) && !stall && !halt_req && in_window);
    end

    // Delivered instruction.
    // The word captured at the start of a stall wins, then live SPM data, then a NOP.
    always_comb begin
        if (hold_v) begin
            if_insn = hold_q;
        end else if (valid_q) begin
            if_insn = i_r_data;
        end else begin
            if_insn = 32'h0000_0000;
        end
        if_en = valid_q;
        if_pc = if_pc_q;
    end

`ifdef YUTORINA_IF_RANGE_CHECK_EN
    assign if_fault = fault_q;
`else
    assign if_fault = 1'b0;
`endif

    // Fetch sequencer.
    // Priority order: reset, flush, halt hold, branch, stall, halt entry, advance.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            pc      <= RESET_VECTOR;
            state   <= RUN;
            if_pc_q <= 32'h0000_0000;
            valid_q <= 1'b0;
            hold_v  <= 1'b0;
            hold_q  <= 32'h0000_0000;
`ifdef YUTORINA_IF_RANGE_CHECK_EN
            fault_q    <= 1'b0;
            fault_lock <= 1'b0;
`endif
        end else begin
`ifdef YUTORINA_IF_RANGE_CHECK_EN
            fault_q <= 1'b0;
`endif
            if (flush) begin
                pc      <= flush_pc;
                valid_q <= 1'b0;
                hold_v  <= 1'b0;
                state   <= RUN;
`ifdef YUTORINA_IF_RANGE_CHECK_EN
                fault_lock <= 1'b0;
`endif
            end else if (state == HALT) begin
                valid_q <= 1'b0;
                hold_v  <= 1'b0;
            end else if (br_taken) begin
                pc      <= br_addr;
                valid_q <= 1'b0;
                hold_v  <= 1'b0;
`ifdef YUTORINA_IF_RANGE_CHECK_EN
                fault_lock <= 1'b0;
`endif
            end else if (stall) begin
                if (!hold_v) begin
                    hold_q <= i_r_data;
                    hold_v <= 1'b1;
                end
            end else if (halt_req) begin
                state   <= HALT;
                valid_q <= 1'b0;
                hold_v  <= 1'b0;
            end else if (!in_window) begin
                valid_q <= 1'b0;
                hold_v  <= 1'b0;
`ifdef YUTORINA_IF_RANGE_CHECK_EN
                if (!fault_lock) begin
                    fault_q    <= 1'b1;
                    fault_lock <= 1'b1;
                end
`endif
            end else begin
                if_pc_q <= pc;
                valid_q <= 1'b1;
                hold_v  <= 1'b0;
                pc      <= pc + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_yutorina_if_stage.sv
// tb_yutorina_if_stage: scoreboard bench for the fetch stage.
// Expected deliveries are queued at fetch issue.
// A monitor pops one entry each cycle the stage hands an instruction downstream.
module tb_yutorina_if_stage;

    logic        clk;
    logic        reset_;
    logic [11:0] i_addr;
    logic        i_as_;
    logic [31:0] i_r_data;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_addr;
    logic        flush;
    logic [31:0] flush_pc;
    logic        halt_req;
    logic [31:0] if_pc;
    logic [31:0] if_insn;
    logic        if_en;
    logic        if_fault;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
    } exp_t;

    exp_t exp_q[$];
    int   total;
    int   bad;

    yutorina_if_stage #(
        .RESET_VECTOR (32'h0000_0000),
        .SPM_BASE     (32'h0000_0000),
        .SPM_AW       (12)
    ) dut (
        .clk      (clk),
        .reset_   (reset_),
        .i_addr   (i_addr),
        .i_as_    (i_as_),
        .i_r_data (i_r_data),
        .stall    (stall),
        .br_taken (br_taken),
        .br_addr  (br_addr),
        .flush    (flush),
        .flush_pc (flush_pc),
        .halt_req (halt_req),
        .if_pc    (if_pc),
        .if_insn  (if_insn),
        .if_en    (if_en),
        .if_fault (if_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SPM model: word n holds n, with read data returned one cycle after the strobe
    always @(posedge clk) begin
        if (!i_as_) begin
            i_r_data <= 32'(i_addr);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pushExp(input logic [31:0] pc, input logic [31:0] insn);
        exp_t e;
        e.pc   = pc;
        e.insn = insn;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs just after the rising edge, then return at mid-cycle
    task automatic applyStimulus(input logic r, input logic s, input logic b,
                                 input logic [31:0] ba, input logic f,
                                 input logic [31:0] fp, input logic h);
        @(posedge clk);
        #1;
        reset_   = r;
        stall    = s;
        br_taken = b;
        br_addr  = ba;
        flush    = f;
        flush_pc = fp;
        halt_req = h;
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    // Monitor: a delivery is any cycle with if_en=1 and no downstream stall
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (if_en === 1'b1 && stall === 1'b0) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL unexpected_delivery: got pc=0x%0h insn=0x%0h expected none", if_pc, if_insn);
                end else begin
                    e = exp_q.pop_front();
                    if (if_pc !== e.pc || if_insn !== e.insn) begin
                        bad++;
                        $display("[TB] FAIL delivery: got pc=0x%0h insn=0x%0h expected pc=0x%0h insn=0x%0h",
                                 if_pc, if_insn, e.pc, e.insn);
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends on its own
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        total    = 0;
        bad      = 0;
        reset_   = 1'b0;
        stall    = 1'b0;
        br_taken = 1'b0;
        br_addr  = 32'h0;
        flush    = 1'b0;
        flush_pc = 32'h0;
        halt_req = 1'b0;

        $display("[TB] reset");
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("rst_if_en", 32'(if_en), 32'h0);
        checkOutput("rst_if_pc", if_pc, 32'h0);
        checkOutput("rst_if_insn", if_insn, 32'h0);
        checkOutput("rst_if_fault", 32'(if_fault), 32'h0);

        $display("[TB] sequential fetch");
        idle();
        checkOutput("first_i_as", 32'(i_as_), 32'h0);
        checkOutput("first_i_addr", 32'(i_addr), 32'h0);
        checkOutput("first_if_en", 32'(if_en), 32'h0);
        pushExp(32'h0, 32'd0);
        idle();
        pushExp(32'h4, 32'd1);
        idle();
        pushExp(32'h8, 32'd2);

        $display("[TB] stall");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            checkOutput("stall_if_pc", if_pc, 32'h8);
            checkOutput("stall_if_insn", if_insn, 32'd2);
            checkOutput("stall_i_as", 32'(i_as_), 32'h1);
        end
        idle();
        checkOutput("release_if_pc", if_pc, 32'h8);
        pushExp(32'hC, 32'd3);
        idle();
        checkOutput("after_stall_if_pc", if_pc, 32'hC);
        checkOutput("after_stall_if_insn", if_insn, 32'd3);

        $display("[TB] branch with stall");
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
        idle();
        checkOutput("br_bubble_en", 32'(if_en), 32'h0);
        checkOutput("br_bubble_insn", if_insn, 32'h0);
        checkOutput("br_i_addr", 32'(i_addr), 32'd16);
        checkOutput("br_i_as", 32'(i_as_), 32'h0);
        pushExp(32'h40, 32'd16);
        idle();
        checkOutput("br_target_pc", if_pc, 32'h40);
        pushExp(32'h44, 32'd17);

        $display("[TB] halt and flush");
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checkOutput("halt_req_i_as", 32'(i_as_), 32'h1);
        for (int i = 0; i < 5; i++) begin
            idle();
            checkOutput("halt_if_en", 32'(if_en), 32'h0);
            checkOutput("halt_i_as", 32'(i_as_), 32'h1);
            checkOutput("halt_if_insn", if_insn, 32'h0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
        checkOutput("flush_if_en", 32'(if_en), 32'h0);
        idle();
        checkOutput("flush_bubble_en", 32'(if_en), 32'h0);
        pushExp(32'h100, 32'd64);
        idle();
        checkOutput("flush_target_pc", if_pc, 32'h100);
        checkOutput("flush_target_en", 32'(if_en), 32'h1);
        pushExp(32'h104, 32'd65);

        $display("[TB] branch beats halt_req");
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 32'h0, 1'b1);
        idle();
        checkOutput("brhalt_bubble_en", 32'(if_en), 32'h0);
        checkOutput("brhalt_i_as", 32'(i_as_), 32'h0);
        checkOutput("brhalt_i_addr", 32'(i_addr), 32'd8);
        pushExp(32'h20, 32'd8);
        idle();
        checkOutput("brhalt_target_pc", if_pc, 32'h20);
        checkOutput("brhalt_target_en", 32'(if_en), 32'h1);

        $display("[TB] reset during stall");
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("midrst_if_en", 32'(if_en), 32'h0);
        checkOutput("midrst_if_pc", if_pc, 32'h0);
        checkOutput("midrst_if_insn", if_insn, 32'h0);
        checkOutput("midrst_if_fault", 32'(if_fault), 32'h0);
        idle();
        checkOutput("resume_i_as", 32'(i_as_), 32'h0);
        checkOutput("resume_i_addr", 32'(i_addr), 32'h0);
        pushExp(32'h0, 32'd0);
        idle();
        pushExp(32'h4, 32'd1);

`ifdef YUTORINA_IF_RANGE_CHECK_EN
        $display("[TB] out-of-window branch");
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0001_0000, 1'b0, 32'h0, 1'b0);
        idle();
        checkOutput("oow_i_as", 32'(i_as_), 32'h1);
        checkOutput("oow_if_en", 32'(if_en), 32'h0);
        checkOutput("oow_fault_pre", 32'(if_fault), 32'h0);
        idle();
        checkOutput("oow_fault_pulse", 32'(if_fault), 32'h1);
        checkOutput("oow_if_en_pulse", 32'(if_en), 32'h0);
        checkOutput("oow_i_as_pulse", 32'(i_as_), 32'h1);
        idle();
        checkOutput("oow_fault_once", 32'(if_fault), 32'h0);
        checkOutput("oow_if_en_after", 32'(if_en), 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
        idle();
        pushExp(32'h0, 32'd0);
`endif

        $display("[TB] final reset");
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
